fp32_to_bf16: RTL and testbench



---
 rtl/fp32_to_bf16.sv | 123 ++++++++++++
 tb/tb_fp32_to_bf16.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fp32_to_bf16.sv
// ----------------------------------------------------------------------------
// fp32_to_bf16
//
// Registered IEEE-754 binary32 -> bfloat16 converter with round-to-nearest-even.
// An enabled cycle converts operand_a and registers the 16-bit result together
// with the exception flags of that conversion. With the enable low, both
// registers hold their values.
//
// Ports
//   clk                 in   1   rising-edge clock
//   reset               in   1   synchronous, active-low reset
//   instruction_enable  in   1   convert operand_a on this edge when 1
//   operand_a           in  32   FP32 operand {sign, exp[7:0], mant[22:0]}
//   result              out 16   BF16 result {sign, exp[7:0], mant[6:0]}
//   fpcsr               out  4   flags {NV, OF, UF, NX} of the last conversion
//
// Configuration
//   FP32_TO_BF16_SUBNORMAL_EN  defined: subnormal inputs are rounded like
//                              normals and may produce BF16 subnormals.
//                              undefined: subnormal inputs flush to signed
//                              zero with UF and NX raised.
// ----------------------------------------------------------------------------
module fp32_to_bf16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        instruction_enable,
    input  logic [31:0] operand_a,
    output logic [15:0] result,
    output logic [3:0]  fpcsr
);

    // Operand fields
    logic        sign;
    logic [7:0]  exp_in;
    logic [22:0] mant_in;

    assign sign    = operand_a[31];
    assign exp_in  = operand_a[30:23];
    assign mant_in = operand_a[22:0];

    // Rounding bits relative to the truncated value operand_a[31:16]
    logic guard;
    logic sticky;
    logic lsb;
    logic round_up;
    logic inexact;

    assign guard    = operand_a[15];
    assign sticky   = |operand_a[14:0];
    assign lsb      = operand_a[16];
    assign round_up = guard & (sticky | lsb);
    assign inexact  = guard | sticky;

    // Rounded magnitude {exp, mant}. A mantissa carry ripples into the
    // exponent naturally. For finite inputs the largest value is 7F7F + 1, so
    // the 15-bit sum cannot wrap.
    logic [14:0] rounded_mag;
    logic        overflow;

    assign rounded_mag = operand_a[30:16] + 15'(round_up);
    assign overflow    = (rounded_mag[14:7] == 8'hFF);

    logic [15:0] next_result;
    logic        flag_nv;
    logic        flag_of;
    logic        flag_uf;
    logic        flag_nx;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        next_result = {sign, rounded_mag};
        flag_nv     = 1'b0;
        flag_of     = 1'b0;
        flag_uf     = 1'b0;
        flag_nx     = 1'b0;

        if (exp_in == 8'hFF) begin
            if (mant_in == 23'd0) begin
                next_result = {sign, 8'hFF, 7'h00};
            end else begin
                // Quiet the NaN and keep the top of the payload; never rounded.
                next_result = {sign, 8'hFF, 1'b1, mant_in[21:16]};
                flag_nv     = ~mant_in[22];
            end
        end else if (exp_in == 8'h00) begin
            if (mant_in == 23'd0) begin
                next_result = {sign, 15'h0000};
            end else begin
`ifdef FP32_TO_BF16_SUBNORMAL_EN
                // Tiny before rounding, so UF tracks NX. Rounding may carry
                // into the smallest normal 0x0080.
                next_result = {sign, rounded_mag};
                flag_nx     = inexact;
                flag_uf     = inexact;
`else
                next_result = {sign, 15'h0000};
                flag_nx     = 1'b1;
                flag_uf     = 1'b1;
`endif
            end
        end else if (overflow) begin
            next_result = {sign, 8'hFF, 7'h00};
            flag_of     = 1'b1;
            flag_nx     = 1'b1;
        end else begin
            flag_nx = inexact;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= 16'h0000;
            fpcsr  <= 4'b0000;
        end else if (instruction_enable) begin
            result <= next_result;
            fpcsr  <= {flag_nv, flag_of, flag_uf, flag_nx};
        end
    end

endmodule

// File: tb/tb_fp32_to_bf16.sv
// ----------------------------------------------------------------------------
// tb_fp32_to_bf16
//
// Directed bench for fp32_to_bf16. The driver applies one vector per cycle
// (shortly after the falling edge) and pushes the value the outputs must show
// after the next rising edge into a queue. An independent monitor pops one
// entry at every falling edge and compares it with result/fpcsr.
// ----------------------------------------------------------------------------
module tb_fp32_to_bf16;

    logic        clk;
    logic        reset;
    logic        instruction_enable;
    logic [31:0] operand_a;
    logic [15:0] result;
    logic [3:0]  fpcsr;

    fp32_to_bf16 dut (
        .clk                (clk),
        .reset              (reset),
        .instruction_enable (instruction_enable),
        .operand_a          (operand_a),
        .result             (result),
        .fpcsr              (fpcsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Expected output state as seen by the bench; used for hold cycles.
    logic [15:0] last_res = 16'h0000;
    logic [3:0]  last_flags = 4'b0000;

    task automatic check(input string name, input logic [15:0] act_res, input logic [3:0] act_flags,
                         input logic [15:0] req_res, input logic [3:0] req_flags);
        tests_run++;
        if (act_res !== req_res || act_flags !== req_flags) begin
            tests_failed++;
            $display("FAIL %s: got result=%h fpcsr=%b, expected result=%h fpcsr=%b",
                     name, act_res, act_flags, req_res, req_flags);
        end
    endtask

    // Monitor: every falling edge the outputs reflect the vector applied in
    // the previous cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, result, fpcsr, e.res, e.flags);
        end
    end

    // Apply one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive(input logic rst_v, input logic en, input logic [31:0] op,
                         input logic [15:0] exp_res, input logic [3:0] exp_flags,
                         input string name);
        exp_t e;
        @(negedge clk);
        #1;
        reset              = rst_v;
        instruction_enable = en;
        operand_a          = op;
        if (!rst_v) begin
            last_res   = 16'h0000;
            last_flags = 4'b0000;
        end else if (en) begin
            last_res   = exp_res;
            last_flags = exp_flags;
        end
        e.res   = last_res;
        e.flags = last_flags;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic conv(input logic [31:0] op, input logic [15:0] r, input logic [3:0] f,
                        input string name);
        drive(1'b1, 1'b1, op, r, f, name);
    endtask

    task automatic hold(input logic [31:0] op, input string name);
        drive(1'b1, 1'b0, op, 16'h0000, 4'b0000, name);
    endtask

    initial begin
        reset              = 1'b0;
        instruction_enable = 1'b0;
        operand_a          = 32'h0;

        // Reset held two cycles with an enabled operand present: discarded.
        drive(1'b0, 1'b1, 32'h3F800000, 16'h0000, 4'b0000, "reset_0");
        drive(1'b0, 1'b1, 32'h3F800000, 16'h0000, 4'b0000, "reset_1");
        hold(32'h0, "after_reset");
        hold(32'h40490FDB, "idle_ignores_operand");

        // Normals and rounding, back to back
        conv(32'h40490FDB, 16'h4049, 4'b0001, "pi");
        conv(32'h3EAAAAAB, 16'h3EAB, 4'b0001, "one_third");
        conv(32'h00800000, 16'h0080, 4'b0000, "min_normal");
        conv(32'h3F808000, 16'h3F80, 4'b0001, "tie_even_down");
        conv(32'h3F818000, 16'h3F82, 4'b0001, "tie_odd_up");
        conv(32'h3F800000, 16'h3F80, 4'b0000, "exact_one");
        hold(32'hFFFFFFFF, "hold_after_exact");
        conv(32'h3F80FFFF, 16'h3F81, 4'b0001, "above_half");
        hold(32'h7F800001, "hold_flags");

        // Specials
        conv(32'h80000000, 16'h8000, 4'b0000, "neg_zero");
        conv(32'hFF800000, 16'hFF80, 4'b0000, "neg_inf");
        conv(32'hFFC00000, 16'hFFC0, 4'b0000, "qnan");
        conv(32'h7F800001, 16'h7FC0, 4'b1000, "snan");
        conv(32'h7FBF0000, 16'h7FFF, 4'b1000, "snan_payload");
        conv(32'h7F7F8000, 16'h7F80, 4'b0101, "overflow_tie");

        // Overflow
        conv(32'h7F7FFFFF, 16'h7F80, 4'b0101, "pos_overflow");
        conv(32'hFF7FFFFF, 16'hFF80, 4'b0101, "neg_overflow");

        // Subnormals
`ifdef FP32_TO_BF16_SUBNORMAL_EN
        conv(32'h007FFFFF, 16'h0080, 4'b0011, "sub_carry_to_normal");
        conv(32'h00010000, 16'h0001, 4'b0000, "sub_exact");
        conv(32'h80000001, 16'h8000, 4'b0011, "sub_tiny_neg");
`else
        conv(32'h007FFFFF, 16'h0000, 4'b0011, "sub_flush");
        conv(32'h80000001, 16'h8000, 4'b0011, "sub_flush_neg");
        conv(32'h00010000, 16'h0000, 4'b0011, "sub_flush_exact");
`endif

        // Reset mid-stream discards the enabled operand on that edge
        conv(32'h40490FDB, 16'h4049, 4'b0001, "pre_reset");
        drive(1'b0, 1'b1, 32'h7F7FFFFF, 16'h0000, 4'b0000, "mid_reset");
        conv(32'h3EAAAAAB, 16'h3EAB, 4'b0001, "post_reset");
        hold(32'h0, "final_hold");

        // Let the monitor drain the last entry.
        @(negedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
